// File: rtl/fpu_round_scheduler.sv
// Round-robin scheduler sharing one rounding datapath between NUM_REQ FPU units,
// with an issue register (S1) and a result register (S2). Optional: FPU_ROUND_DYN_FRM_EN.
module fpu_round_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
`ifdef FPU_ROUND_DYN_FRM_EN
   input  logic [2:0]                 csr_frm,
`endif
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [3*NUM_REQ-1:0]       req_rm,
   input  logic [NUM_REQ-1:0]         req_is_zero,
   input  logic [9*NUM_REQ-1:0]       req_sign_exp,
   input  logic [32*NUM_REQ-1:0]      req_mant,
   input  logic [TAG_W*NUM_REQ-1:0]   req_tag,
   output logic [2:0]                 ru_rm,
   output logic                       ru_is_zero,
   output logic [8:0]                 ru_sign_exp,
   output logic [31:0]                ru_mant,
   input  logic [31:0]                ru_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_result,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(NUM_REQ)-1:0] out_src,
   output logic                       busy
);

   localparam int SRC_W = $clog2(NUM_REQ);

   logic              r_s1Valid;
   logic [2:0]        r_s1Rm;
   logic              r_s1IsZero;
   logic [8:0]        r_s1SignExp;
   logic [31:0]       r_s1Mant;
   logic [TAG_W-1:0]  r_s1Tag;
   logic [SRC_W-1:0]  r_s1Src;
   logic              r_s2Valid;
   logic [31:0]       r_outResult;
   logic [TAG_W-1:0]  r_outTag;
   logic [SRC_W-1:0]  r_outSrc;
   logic [SRC_W-1:0]  r_rrPtr;

   logic              w_s2Adv;
   logic              w_s1Acc;
   logic              w_grantValid;
   logic [SRC_W-1:0]  w_grantIdx;
   logic [2:0]        w_grantRm;
   logic [2:0]        w_effRm;

   function automatic logic [SRC_W-1:0] wrapIdx(input logic [SRC_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return SRC_W'(sum);
   endfunction

   assign w_s2Adv = r_s1Valid & (~r_s2Valid | out_ready);
   assign w_s1Acc = ~r_s1Valid | w_s2Adv;

   // First asserted requester at or after the round-robin pointer, wrapping around.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_grantValid && req_valid[wrapIdx(r_rrPtr, k)]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = wrapIdx(r_rrPtr, k);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && w_s1Acc && w_grantValid) req_ready[w_grantIdx] = 1'b1;
   end

   assign w_grantRm = req_rm[int'(w_grantIdx)*3 +: 3];

`ifdef FPU_ROUND_DYN_FRM_EN
   assign w_effRm = (w_grantRm == 3'b111) ? csr_frm : w_grantRm;
`else
   assign w_effRm = w_grantRm;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid   <= 1'b0;
         r_s1Rm      <= '0;
         r_s1IsZero  <= 1'b0;
         r_s1SignExp <= '0;
         r_s1Mant    <= '0;
         r_s1Tag     <= '0;
         r_s1Src     <= '0;
         r_rrPtr     <= '0;
      end else if (w_s1Acc) begin
         r_s1Valid <= w_grantValid;
         if (w_grantValid) begin
            r_s1Rm      <= w_effRm;
            r_s1IsZero  <= req_is_zero[w_grantIdx];
            r_s1SignExp <= req_sign_exp[int'(w_grantIdx)*9 +: 9];
            r_s1Mant    <= req_mant[int'(w_grantIdx)*32 +: 32];
            r_s1Tag     <= req_tag[int'(w_grantIdx)*TAG_W +: TAG_W];
            r_s1Src     <= w_grantIdx;
            r_rrPtr     <= wrapIdx(w_grantIdx, 1);
         end
      end
   end

   // Exact zeros bypass the datapath but keep their sign.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid   <= 1'b0;
         r_outResult <= '0;
         r_outTag    <= '0;
         r_outSrc    <= '0;
      end else if (w_s2Adv) begin
         r_s2Valid   <= 1'b1;
         r_outResult <= r_s1IsZero ? {r_s1SignExp[8], 31'b0} : ru_result;
         r_outTag    <= r_s1Tag;
         r_outSrc    <= r_s1Src;
      end else if (out_ready) begin
         r_s2Valid   <= 1'b0;
      end
   end

   assign ru_rm       = r_s1Rm;
   assign ru_is_zero  = r_s1IsZero;
   assign ru_sign_exp = r_s1SignExp;
   assign ru_mant     = r_s1Mant;
   assign out_valid   = r_s2Valid;
   assign out_result  = r_outResult;
   assign out_tag     = r_outTag;
   assign out_src     = r_outSrc;
   assign busy        = r_s1Valid | r_s2Valid;

endmodule

// File: tb/tb_fpu_round_scheduler.sv
// Testbench for fpu_round_scheduler: supplies a behavioural rounding datapath and
// checks arbitration, ordering and results against a queue-based model every cycle.
module tb_fpu_round_scheduler;

   localparam int NUM_REQ = 4;
   localparam int TAG_W   = 4;
   localparam int SRC_W   = $clog2(NUM_REQ);

   logic                      clk;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        reqValid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [3*NUM_REQ-1:0]      reqRm;
   logic [NUM_REQ-1:0]        reqIsZero;
   logic [9*NUM_REQ-1:0]      reqSignExp;
   logic [32*NUM_REQ-1:0]     reqMant;
   logic [TAG_W*NUM_REQ-1:0]  reqTag;
   logic [2:0]                ru_rm;
   logic                      ru_is_zero;
   logic [8:0]                ru_sign_exp;
   logic [31:0]               ru_mant;
   logic [31:0]               ruResult;
   logic                      out_valid;
   logic                      outReady;
   logic [31:0]               out_result;
   logic [TAG_W-1:0]          out_tag;
   logic [SRC_W-1:0]          out_src;
   logic                      busy;
`ifdef FPU_ROUND_DYN_FRM_EN
   logic [2:0]                csrFrm;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   fpu_round_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef FPU_ROUND_DYN_FRM_EN
      .csr_frm      (csrFrm),
`endif
      .req_valid    (reqValid),
      .req_ready    (req_ready),
      .req_rm       (reqRm),
      .req_is_zero  (reqIsZero),
      .req_sign_exp (reqSignExp),
      .req_mant     (reqMant),
      .req_tag      (reqTag),
      .ru_rm        (ru_rm),
      .ru_is_zero   (ru_is_zero),
      .ru_sign_exp  (ru_sign_exp),
      .ru_mant      (ru_mant),
      .ru_result    (ruResult),
      .out_valid    (out_valid),
      .out_ready    (outReady),
      .out_result   (out_result),
      .out_tag      (out_tag),
      .out_src      (out_src),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rounding: {sign,exp,frac} plus an increment decided by the mode;
   // a carry out of the fraction naturally bumps the exponent.
   function automatic logic [31:0] roundRef(input logic [2:0] rm, input logic [8:0] se,
                                            input logic [31:0] mant);
      logic g, r, st, inexact, inc;
      g       = mant[8];
      r       = mant[7];
      st      = |mant[6:0];
      inexact = g | r | st;
      case (rm)
         3'b001:  inc = 1'b0;
         3'b010:  inc = se[8] & inexact;
         3'b011:  inc = ~se[8] & inexact;
         3'b100:  inc = g;
         default: inc = g & (r | st | mant[9]);
      endcase
      return {se, mant[31:9]} + {31'b0, inc};
   endfunction

   // The external rounding datapath the scheduler feeds.
   always_comb ruResult = roundRef(ru_rm, ru_sign_exp, ru_mant);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timed out waiting for out_valid", name);
   endtask

   task automatic setReq(input int i, input logic v, input logic [2:0] rm, input logic z,
                         input logic [8:0] se, input logic [31:0] m, input logic [TAG_W-1:0] t);
      reqValid[i]             = v;
      reqRm[i*3 +: 3]         = rm;
      reqIsZero[i]            = z;
      reqSignExp[i*9 +: 9]    = se;
      reqMant[i*32 +: 32]     = m;
      reqTag[i*TAG_W +: TAG_W] = t;
   endtask

   task automatic clearReqs();
      reqValid   = '0;
      reqRm      = '0;
      reqIsZero  = '0;
      reqSignExp = '0;
      reqMant    = '0;
      reqTag     = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random traffic, random back-pressure and the occasional reset.
   task automatic applyStimulus();
      for (int i = 0; i < NUM_REQ; i++)
         setReq(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 7) == 0, 9'($urandom), $urandom, TAG_W'($urandom));
      outReady = $urandom_range(0, 3) != 0;
      rst_n    = $urandom_range(0, 499) != 0;
`ifdef FPU_ROUND_DYN_FRM_EN
      csrFrm   = 3'($urandom_range(0, 4));
`endif
   endtask

   task automatic waitResult(input string name, input logic [31:0] expected);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) failNow(name);
      else checkOutput(name, out_result, expected);
   endtask

   function automatic int onehotIdx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Model: results leave in accept order; an entry accepted before edge k
   // reaches the output at the negedge two cycles later if it is the oldest.
   // Two entries fill the pipe; a third is taken only while the head drains.
   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      int               src;
      int               acc;
   } entry_t;

   entry_t modelQ[$];
   int     rrPtr = 0;
   int     cyc   = 0;

   function automatic int expectedGrant();
      int i;
      for (int k = 0; k < NUM_REQ; k++) begin
         i = (rrPtr + k) % NUM_REQ;
         if (reqValid[i]) return i;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int               g;
      bit               expValid;
      logic [NUM_REQ-1:0] expReady;
      logic [2:0]       rmEff;
      entry_t           e;
      if (!rst_n) begin
         checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
         checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
         checkOutput("reset_busy", 32'(busy), 32'h0);
         checkOutput("reset_out_result", out_result, 32'h0);
         checkOutput("reset_out_tag_src", {out_tag, 28'(out_src)}, 32'h0);
         modelQ.delete();
         rrPtr = 0;
      end else begin
         expValid = modelQ.size() > 0 && modelQ[0].acc + 2 <= cyc;
         g = (modelQ.size() < 2 || outReady) ? expectedGrant() : -1;
         expReady = '0;
         if (g >= 0) expReady[g] = 1'b1;
         checkOutput("req_ready", 32'(req_ready), 32'(expReady));
         checkOutput("out_valid", 32'(out_valid), 32'(expValid));
         checkOutput("busy", 32'(busy), 32'(modelQ.size() > 0));
         if (expValid) begin
            checkOutput("out_result", out_result, modelQ[0].res);
            checkOutput("out_tag", 32'(out_tag), 32'(modelQ[0].tag));
            checkOutput("out_src", 32'(out_src), 32'(modelQ[0].src));
            if (outReady) void'(modelQ.pop_front());
         end
         if (g >= 0) begin
            rmEff = reqRm[g*3 +: 3];
`ifdef FPU_ROUND_DYN_FRM_EN
            if (rmEff == 3'b111) rmEff = csrFrm;
`endif
            e.res = reqIsZero[g] ? {reqSignExp[g*9+8], 31'b0}
                                 : roundRef(rmEff, reqSignExp[g*9 +: 9], reqMant[g*32 +: 32]);
            e.tag = reqTag[g*TAG_W +: TAG_W];
            e.src = g;
            e.acc = cyc;
            modelQ.push_back(e);
            rrPtr = (g + 1) % NUM_REQ;
         end
      end
      cyc++;
   end

   initial begin
      int accepts;
      rst_n    = 1'b1;
      outReady = 1'b0;
      clearReqs();
`ifdef FPU_ROUND_DYN_FRM_EN
      csrFrm   = 3'b000;
`endif
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single request from requester 0, with exact two-edge latency.
      setReq(0, 1'b1, 3'b000, 1'b0, 9'h07F, 32'h0000_0180, 4'h5);
      outReady = 1'b1;
      tick();
      clearReqs();
      @(negedge clk);
      checkOutput("latency_first_cycle", 32'(out_valid), 32'h0);
      @(negedge clk);
      checkOutput("latency_second_cycle", 32'(out_valid), 32'h1);
      checkOutput("single_result", out_result, 32'h3F80_0001);
      checkOutput("single_src", 32'(out_src), 32'h0);
      checkOutput("single_tag", 32'(out_tag), 32'h5);
      tick();

      // Signed exact zero overrides the mantissa and rounding mode.
      setReq(2, 1'b1, 3'($urandom_range(0, 7)), 1'b1, 9'h1AB, 32'hFFFF_FFFF, 4'hA);
      tick();
      clearReqs();
      waitResult("zero_result", 32'h8000_0000);
      tick();

      // Round-up with mantissa overflow into the exponent.
      setReq(1, 1'b1, 3'b011, 1'b0, 9'h07F, 32'hFFFF_FE01, 4'h3);
      tick();
      clearReqs();
      waitResult("overflow_result", 32'h4000_0000);
      repeat (3) tick();

      // Back-pressure with three requesters: only two entries fit.
      outReady = 1'b0;
      for (int i = 0; i < 3; i++)
         setReq(i, 1'b1, 3'($urandom_range(0, 4)), 1'b0, 9'($urandom), $urandom, TAG_W'(i + 8));
      accepts = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (|(req_ready & reqValid)) accepts++;
         if (c == 4) checkOutput("bp_ready_blocked", 32'(req_ready), 32'h0);
         tick();
      end
      checkOutput("bp_accepts", 32'(accepts), 32'd2);
      clearReqs();
      outReady = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checkOutput("bp_drained_busy", 32'(busy), 32'h0);
      tick();

      // Fill both stages, then reset: everything drops and the pointer returns to 0.
      outReady = 1'b0;
      setReq(1, 1'b1, 3'b001, 1'b0, 9'h080, 32'h1234_5678, 4'h1);
      setReq(2, 1'b1, 3'b010, 1'b0, 9'h180, 32'h8765_4321, 4'h2);
      repeat (3) tick();
      checkOutput("full_before_reset", {31'b0, busy & out_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_immediate_valid", 32'(out_valid), 32'h0);
      checkOutput("reset_immediate_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      outReady = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         setReq(i, 1'b1, 3'(i), 1'b0, 9'(8'h70 + i), 32'h00AB_CD00 + i, TAG_W'(i));

      // All requesters valid: strict rotation starting at requester 0.
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("rr_grant", 32'(onehotIdx(req_ready)), 32'(c % NUM_REQ));
         tick();
      end
      clearReqs();
      repeat (3) tick();

      repeat (3000) begin
         applyStimulus();
         tick();
      end

      rst_n    = 1'b1;
      outReady = 1'b1;
      clearReqs();
      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fpu_round_scheduler.md
Name: fpu_round_scheduler

Overview:
Shares one rounding datapath between NUM_REQ upstream FPU units (adder, multiplier, divider, int-to-float converter). Round-robin arbitration across per-requester valid/ready ports. Two-stage pipeline: an issue register drives the combinational rounding datapath through ru_* ports, and a result register captures the packed float. Tagged, back-pressured result port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TAG_W, 4, width of the per-request tag carried to the result

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
req_rm  in  3*NUM_REQ  rounding mode per requester; 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
req_is_zero  in  NUM_REQ  result is exact zero
req_sign_exp  in  9*NUM_REQ  {sign, exponent[7:0]}
req_mant  in  32*NUM_REQ  mantissa candidate; [31:9] fraction, [8:0] guard/round/sticky source
req_tag  in  TAG_W*NUM_REQ  opaque tag
ru_rm  out  3  to the rounding datapath
ru_is_zero  out  1  to the rounding datapath
ru_sign_exp  out  9  to the rounding datapath
ru_mant  out  32  to the rounding datapath
ru_result  in  32  combinational rounded float from the rounding datapath
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_result  out  32  rounded IEEE-754 single
out_tag  out  TAG_W  tag of the request
out_src  out  $clog2(NUM_REQ)  index of the originating requester
busy  out  1  s1_valid | s2_valid

Behaviour:
- Reset (async assert, sync-release assumed upstream): s1_valid=0, s2_valid=0, rr_ptr=0, out_valid=0, out_result=0, out_tag=0, out_src=0, busy=0. req_ready is 0 while rst_n=0.
- Stage S2 (result register) advances when s2_adv = s1_valid & (~s2_valid | out_ready). On s2_adv it loads out_result = (s1_is_zero ? {s1_sign,31'b0} : ru_result), plus out_tag and out_src. s2_valid is set on s2_adv and cleared when out_ready & ~s2_adv.
- Stage S1 (issue register) accepts when s1_acc = ~s1_valid | s2_adv. ru_* are driven directly from the S1 register and are held stable while s1_valid=1 and not advancing.
- Arbitration: when s1_acc=1, grant the first asserted req_valid searching from index rr_ptr upward with wrap. req_ready[g]=1 only for the granted index. On a grant, S1 loads the request fields and src=g, and rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr is held.
- req_ready may depend combinationally on req_valid, out_ready and state. Requesters must not make req_valid depend on req_ready.
- Latency: request accepted at edge T produces out_valid=1 after edge T+1 (visible in the cycle after T+1). Throughput is 1 result/cycle with out_ready held high.
- Full pipeline (both stages valid, out_ready=0): all req_ready=0, contents held unchanged.
- Simultaneous out_ready handshake and S1 advance: the pipeline shifts with no bubble.
- Invalid req_rm (101, 110): forwarded unchanged; the datapath treats it as RNE.
- Reset mid-operation drops in-flight entries with no result. rr_ptr returns to 0.

Optional Feature:
FPU_ROUND_DYN_FRM_EN
- With the macro defined: adds port csr_frm (in, 3 bits). A request with req_rm=111 (DYN) is latched into S1 with rm=csr_frm sampled at the grant cycle.
- Without the macro: no csr_frm port. req_rm=111 is forwarded unchanged, and the datapath treats it as RNE.

Test Plan:
- Single requester 0: rm=000, sign_exp=9'h07F, mant=32'h0000_0180 (G=1, R=1) -> out_result=32'h3F80_0001 two cycles after accept, out_src=0, tag preserved.
- All 4 requesters valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,... with one grant per cycle and out_src following the same sequence.
- Back-pressure: out_ready=0 for 5 cycles with 3 requesters valid -> exactly 2 accepts, then all req_ready=0. out_result is stable and no entry is lost or duplicated after release.
- is_zero=1, sign=1, mant=32'hFFFF_FFFF -> out_result=32'h8000_0000 regardless of rm.
- Mantissa overflow: rm=011, sign=0, exp=8'h7F, mant=32'hFFFF_FE01 -> out_result=32'h4000_0000.
- Assert rst_n=0 with both stages full -> out_valid=0 and busy=0 immediately. After release, requester 0 wins first.
